// File: rtl/conv_row_buf_writer_if.sv
// Pixel stream into the row buffer writer: one word of PIXELS_IN_ROW pixels per beat,
// transferred when valid and ready are both high.
interface conv_row_buf_writer_if #(
  parameter int unsigned PIXELS_IN_ROW = 32
) ();
  logic                         valid;
  logic                         ready;
  logic [PIXELS_IN_ROW*8-1:0]   pixels;

  modport master (output valid, output pixels, input ready);
  modport slave  (input valid, input pixels, output ready);
endinterface

// File: rtl/conv_row_buf_writer.sv
// Fill side of the three-row convolution line buffer: writes stream rows into buf1..buf3
// in rotation and publishes the oldest/middle/newest row-to-buffer mapping.
module conv_row_buf_writer #(
  parameter int unsigned PIXELS_IN_ROW = 32,
  parameter int unsigned ADR_W         = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start_i,
  input  logic [ADR_W-1:0]           cfg_base_adr_i,
  input  logic [ADR_W-1:0]           cfg_words_per_row_i,
  input  logic [ADR_W-1:0]           cfg_rows_i,
  conv_row_buf_writer_if.slave       in_if,
  output logic [PIXELS_IN_ROW*8-1:0] wr_data_o,
  output logic [ADR_W-1:0]           wr_adr_o,
  output logic                       buf1_we_o,
  output logic                       buf2_we_o,
  output logic                       buf3_we_o,
  input  logic                       row_release_i,
  output logic [1:0]                 row1_buf_idx_o,
  output logic [1:0]                 row2_buf_idx_o,
  output logic [1:0]                 row3_buf_idx_o,
  output logic                       window_valid_o,
  output logic [ADR_W-1:0]           rows_committed_o,
  output logic                       done_o
);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_e;

  state_e                     state_q, state_d;
  logic [1:0]                 head_q, head_d, occ_q, occ_d, tail;
  logic [ADR_W-1:0]           word_cnt_q, word_cnt_d, rows_q, rows_d;
  logic [ADR_W-1:0]           base_q, wpr_q, rows_cfg_q;
  logic                       in_ready_q;
  logic                       buf1_we_q, buf2_we_q, buf3_we_q;
  logic [ADR_W-1:0]           wr_adr_q;
  logic [PIXELS_IN_ROW*8-1:0] wr_data_q;
  logic [1:0]                 row1_q, row2_q, row3_q;
  logic                       window_valid_q, done_q;
  logic                       start_ok, accept, last_beat, commit, release_ok;

  // Next buffer in the 1->2->3->1 rotation.
  function automatic logic [1:0] rot1(input logic [1:0] b);
    return (b == 2'd3) ? 2'd1 : b + 2'd1;
  endfunction

  always_comb begin
    case (occ_q)
      2'd0:    tail = head_q;
      2'd1:    tail = rot1(head_q);
      default: tail = rot1(rot1(head_q));
    endcase
  end

  always_comb begin
    start_ok   = start_i && (state_q != S_FILL);
    accept     = in_if.valid && in_ready_q;
    last_beat  = (word_cnt_q == wpr_q - ADR_W'(1));
    commit     = accept && last_beat;
    release_ok = row_release_i && (occ_q != 2'd0);

    state_d    = state_q;
    head_d     = head_q;
    occ_d      = occ_q;
    word_cnt_d = word_cnt_q;
    rows_d     = rows_q;

    if (start_ok) begin
      state_d    = S_FILL;
      head_d     = 2'd1;
      occ_d      = 2'd0;
      word_cnt_d = '0;
      rows_d     = '0;
    end else begin
      if (accept) word_cnt_d = last_beat ? '0 : word_cnt_q + ADR_W'(1);
      if (release_ok) head_d = rot1(head_q);
      // Commit and release in the same cycle cancel out in occupancy.
      occ_d = occ_q + 2'(commit) - 2'(release_ok);
      if (commit && (rows_q != rows_cfg_q)) begin
        rows_d = rows_q + ADR_W'(1);
        if (rows_d == rows_cfg_q) state_d = S_DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      head_q         <= 2'd1;
      occ_q          <= 2'd0;
      word_cnt_q     <= '0;
      rows_q         <= '0;
      base_q         <= '0;
      wpr_q          <= '0;
      rows_cfg_q     <= '0;
      in_ready_q     <= 1'b0;
      buf1_we_q      <= 1'b0;
      buf2_we_q      <= 1'b0;
      buf3_we_q      <= 1'b0;
      wr_adr_q       <= '0;
      wr_data_q      <= '0;
      row1_q         <= 2'd0;
      row2_q         <= 2'd0;
      row3_q         <= 2'd0;
      window_valid_q <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      occ_q      <= occ_d;
      word_cnt_q <= word_cnt_d;
      rows_q     <= rows_d;
      if (start_ok) begin
        base_q     <= cfg_base_adr_i;
        wpr_q      <= cfg_words_per_row_i;
        rows_cfg_q <= cfg_rows_i;
      end
      in_ready_q <= (state_d == S_FILL) && (occ_d != 2'd3);
      buf1_we_q  <= accept && (tail == 2'd1);
      buf2_we_q  <= accept && (tail == 2'd2);
      buf3_we_q  <= accept && (tail == 2'd3);
      if (accept) begin
        wr_adr_q  <= base_q + word_cnt_q;
        wr_data_q <= in_if.pixels;
      end
      // Mapping follows occupancy one cycle late so a committed row is already in BRAM.
      row1_q         <= (occ_q >= 2'd1) ? head_q : 2'd0;
      row2_q         <= (occ_q >= 2'd2) ? rot1(head_q) : 2'd0;
      row3_q         <= (occ_q == 2'd3) ? rot1(rot1(head_q)) : 2'd0;
      window_valid_q <= (occ_q == 2'd3);
      done_q         <= (state_d == S_DONE);
    end
  end

  assign in_if.ready      = in_ready_q;
  assign wr_data_o        = wr_data_q;
  assign wr_adr_o         = wr_adr_q;
  assign buf1_we_o        = buf1_we_q;
  assign buf2_we_o        = buf2_we_q;
  assign buf3_we_o        = buf3_we_q;
  assign row1_buf_idx_o   = row1_q;
  assign row2_buf_idx_o   = row2_q;
  assign row3_buf_idx_o   = row3_q;
  assign window_valid_o   = window_valid_q;
  assign rows_committed_o = rows_q;
  assign done_o           = done_q;

endmodule

// File: tb/tb_conv_row_buf_writer.sv
// Directed bench for conv_row_buf_writer: a queue-of-resident-rows model checked every
// cycle, plus hand-computed literal expectations at key points of each scenario.
module tb_conv_row_buf_writer;

  logic         clk = 1'b0;
  logic         reset, start, valid, rel;
  logic [15:0]  base, wpr, rows;
  logic [255:0] pix;
  logic [255:0] wr_data;
  logic [15:0]  wr_adr, rc;
  logic         we1, we2, we3, win, done;
  logic [1:0]   idx1, idx2, idx3;
  int           n_cmp = 0, n_fail = 0, cyc_n = 0;

  conv_row_buf_writer_if #(.PIXELS_IN_ROW(32)) sif ();
  assign sif.valid  = valid;
  assign sif.pixels = pix;

  conv_row_buf_writer #(.PIXELS_IN_ROW(32), .ADR_W(16)) dut (
    .clk(clk), .reset(reset), .start_i(start),
    .cfg_base_adr_i(base), .cfg_words_per_row_i(wpr), .cfg_rows_i(rows),
    .in_if(sif), .wr_data_o(wr_data), .wr_adr_o(wr_adr),
    .buf1_we_o(we1), .buf2_we_o(we2), .buf3_we_o(we3), .row_release_i(rel),
    .row1_buf_idx_o(idx1), .row2_buf_idx_o(idx2), .row3_buf_idx_o(idx3),
    .window_valid_o(win), .rows_committed_o(rc), .done_o(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Model: resident rows are a queue of buffer ids; each committed row goes to the buffer after the last.
  int           q[$];
  int           m_state, m_next, e_we;
  logic [15:0]  m_wc, m_rc, m_base, m_wpr, m_rows, e_adr;
  logic [255:0] e_data;
  logic         e_ready, e_win, e_done, m_live = 1'b0, acc;
  int           e_i1, e_i2, e_i3;

  always @(posedge clk) begin
    if (reset) begin
      m_live = 1'b1; m_state = 0; q.delete(); m_next = 1; m_wc = 0; m_rc = 0;
      e_we = 0; e_adr = 0; e_data = 0; e_ready = 0; e_win = 0; e_done = 0;
      e_i1 = 0; e_i2 = 0; e_i3 = 0;
    end else if (m_live) begin
      acc   = e_ready && valid;
      e_i1  = (q.size() > 0) ? q[0] : 0;
      e_i2  = (q.size() > 1) ? q[1] : 0;
      e_i3  = (q.size() > 2) ? q[2] : 0;
      e_win = (q.size() == 3);
      e_we  = 0;
      if (start && m_state != 1) begin
        m_base = base; m_wpr = wpr; m_rows = rows;
        m_state = 1; q.delete(); m_next = 1; m_wc = 0; m_rc = 0;
      end else begin
        if (acc) begin
          e_we = m_next; e_adr = m_base + m_wc; e_data = pix;
        end
        if (rel && q.size() > 0) void'(q.pop_front());
        if (acc) begin
          if (m_wc == 16'(m_wpr - 16'd1)) begin
            m_wc = 0;
            q.push_back(m_next);
            m_next = m_next % 3 + 1;
            if (m_rc < m_rows) m_rc = m_rc + 16'd1;
            if (m_rc == m_rows) m_state = 2;
          end else m_wc = m_wc + 16'd1;
        end
      end
      e_done  = (m_state == 2);
      e_ready = (m_state == 1) && (q.size() < 3);
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("in_ready", 256'(sif.ready), 256'(e_ready));
      check("buf1_we", 256'(we1), 256'(e_we == 1));
      check("buf2_we", 256'(we2), 256'(e_we == 2));
      check("buf3_we", 256'(we3), 256'(e_we == 3));
      check("wr_adr", 256'(wr_adr), 256'(e_adr));
      check("wr_data", wr_data, e_data);
      check("row1_idx", 256'(idx1), 256'(e_i1));
      check("row2_idx", 256'(idx2), 256'(e_i2));
      check("row3_idx", 256'(idx3), 256'(e_i3));
      check("window_valid", 256'(win), 256'(e_win));
      check("rows_committed", 256'(rc), 256'(m_rc));
      check("done", 256'(done), 256'(e_done));
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      cyc_n++;
      pix = {8{32'hC0DE0000 ^ 32'(cyc_n)}};
    end
  endtask

  task automatic pin_map(input string nm, input int a, input int b, input int c, input logic w);
    check({nm, "_row1"}, 256'(idx1), 256'(a));
    check({nm, "_row2"}, 256'(idx2), 256'(b));
    check({nm, "_row3"}, 256'(idx3), 256'(c));
    check({nm, "_win"}, 256'(win), 256'(w));
  endtask

  initial begin
    reset = 1; start = 0; valid = 0; rel = 0; base = 0; wpr = 0; rows = 0; pix = '0;
    cyc(3); reset = 0; cyc(1);
    check("reset_ready", 256'(sif.ready), 256'(0));
    check("reset_row1", 256'(idx1), 256'(0));

    // Continuous stream, 2 words/row, 4 rows at base 0x10
    base = 16'h10; wpr = 16'd2; rows = 16'd4; start = 1; valid = 1;
    cyc(1); start = 0;
    cyc(1);
    check("t1_first_we", 256'(we1), 256'(1));
    check("t1_first_adr", 256'(wr_adr), 256'(16'h10));
    cyc(6);
    pin_map("t1_full", 1, 2, 3, 1'b1);
    check("t1_ready_low", 256'(sif.ready), 256'(0));
    check("t1_rc", 256'(rc), 256'(3));

    // Release the oldest row; row 4 lands in buf1
    rel = 1; cyc(1); rel = 0;
    cyc(1);
    pin_map("t2_release", 2, 3, 0, 1'b0);
    check("t2_we_buf1", 256'(we1), 256'(1));
    check("t2_adr", 256'(wr_adr), 256'(16'h10));
    cyc(2);
    pin_map("t2_final", 2, 3, 1, 1'b1);
    check("t2_rc", 256'(rc), 256'(4));
    check("t2_done", 256'(done), 256'(1));
    check("t2_ready", 256'(sif.ready), 256'(0));
    valid = 0;

    // Restart from DONE with a bursty source and an address range that wraps
    base = 16'hFFFF; start = 1; cyc(1); start = 0;
    for (int i = 0; i < 20; i++) begin
      valid = (i % 2 == 0);
      cyc(1);
    end
    valid = 0; cyc(3);
    pin_map("t3_full", 1, 2, 3, 1'b1);
    check("t3_rc", 256'(rc), 256'(3));
    check("t3_done", 256'(done), 256'(0));
    rel = 1; cyc(1); rel = 0; valid = 1; cyc(4); valid = 0; cyc(2);
    check("t3_done_end", 256'(done), 256'(1));
    check("t3_rc_end", 256'(rc), 256'(4));

    // Release at occ=0 and start during FILL are both ignored
    base = 16'h20; wpr = 16'd1; rows = 16'd5; start = 1; cyc(1); start = 0;
    rel = 1; start = 1; rows = 16'd9; cyc(1); rel = 0; start = 0;
    cyc(2);
    pin_map("t6_empty", 0, 0, 0, 1'b0);
    check("t6_ready", 256'(sif.ready), 256'(1));
    check("t6_rc", 256'(rc), 256'(0));
    check("t6_we", 256'(we1), 256'(0));

    // Release coincident with the 3rd row's commit
    valid = 1; cyc(2); rel = 1; cyc(1); rel = 0; valid = 0;
    cyc(1);
    pin_map("t4_coincide", 2, 3, 0, 1'b0);
    valid = 1; cyc(1); valid = 0;
    check("t4_we_buf1", 256'(we1), 256'(1));
    check("t4_adr", 256'(wr_adr), 256'(16'h20));
    cyc(2);
    pin_map("t4_final", 2, 3, 1, 1'b1);
    check("t4_rc", 256'(rc), 256'(4));
    check("t4_done", 256'(done), 256'(0));

    // Reset mid-row discards the partial row
    reset = 1; cyc(1); reset = 0;
    base = 16'h40; wpr = 16'd3; rows = 16'd2; start = 1; cyc(1); start = 0;
    valid = 1; cyc(4);
    reset = 1; cyc(1);
    check("t5_we", 256'({we1, we2, we3}), 256'(0));
    check("t5_adr", 256'(wr_adr), 256'(0));
    check("t5_data", wr_data, 256'(0));
    check("t5_ready", 256'(sif.ready), 256'(0));
    check("t5_rc", 256'(rc), 256'(0));
    pin_map("t5_map", 0, 0, 0, 1'b0);
    reset = 0; start = 1; cyc(1); start = 0;
    cyc(1);
    check("t5_restart_we", 256'(we1), 256'(1));
    check("t5_restart_adr", 256'(wr_adr), 256'(16'h40));
    valid = 0; cyc(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_row_buf_writer.md
Name: conv_row_buf_writer

Overview:
Fill side of the three-row convolution line buffer. Accepts a stream of 32-pixel words over a valid/ready handshake and writes each image row into one of the three row buffer BRAMs (buf1..buf3), rotating 1->2->3->1. It publishes the logical-row-to-buffer mapping (row1/row2/row3 buffer index, where 0 means empty) consumed by the convolution read path. A buffer is refilled only after the consumer releases the oldest row.

Parameters:
PIXELS_IN_ROW, 32, pixels per stream word and per BRAM word (data width PIXELS_IN_ROW*8)
ADR_W, 16, BRAM address width and configuration counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
start  in  1  pulse; latches cfg_* and begins a frame (honoured in IDLE or DONE only)
cfg_base_adr  in  ADR_W  BRAM address of word 0 of every row
cfg_words_per_row  in  ADR_W  words per row, >=1
cfg_rows  in  ADR_W  rows per frame, >=1
in_valid  in  1  stream word valid
in_ready  out  1  stream word accepted when in_valid&&in_ready
in_pixels  in  PIXELS_IN_ROW*8  stream word
wr_data  out  PIXELS_IN_ROW*8  write data, shared by all buffers
wr_adr  out  ADR_W  write address, shared by all buffers
buf1_we, buf2_we, buf3_we  out  1 each  per-buffer write strobe, at most one high
row_release  in  1  pulse; consumer is finished with the oldest row
row1_buf_idx, row2_buf_idx, row3_buf_idx  out  2 each  buffer (1..3) holding oldest/middle/newest row; 0 = none
window_valid  out  1  all three rows resident
rows_committed  out  ADR_W  rows fully written this frame
done  out  1  all cfg_rows rows committed

Behaviour:
- Reset: in_ready=0, all we=0, wr_adr=0, wr_data=0, all idx=0, window_valid=0, rows_committed=0, done=0; state IDLE, head=1, occ=0, word_cnt=0. Reset mid-row discards the partial row; no write strobe is issued in the cycle after reset.
- States: IDLE -(start)-> FILL -(rows_committed reaches cfg_rows)-> DONE -(start)-> FILL. A start in DONE clears occ, head=1, rows_committed=0. A start in FILL is ignored.
- occ (0..3) counts resident rows. head is the buffer holding the oldest row. tail = head rotated by occ (1->2->3->1) is the buffer being filled.
- in_ready = (state==FILL) && (occ<3). It is registered and combinationally independent of in_valid.
- A beat accepted in cycle N drives cycle N+1: we of tail=1, wr_adr=cfg_base_adr+word_cnt, wr_data=in_pixels. Otherwise all we=0 and wr_adr/wr_data hold.
- word_cnt increments per accepted beat and wraps to 0 after cfg_words_per_row-1. That last beat commits the row: in cycle N+1 (same cycle as its we), occ++ and rows_committed++. The new mapping is visible from N+2, so the data is in BRAM before any read.
- Mapping: row1_buf_idx = occ>=1 ? head : 0; row2 = occ>=2 ? head+1 : 0; row3 = occ==3 ? head+2 : 0 (mod-3 rotation over 1..3). window_valid = (occ==3). These are registered outputs.
- row_release: if occ>0, head rotates +1 and occ-- next cycle. If occ==0 it is ignored.
- Simultaneous commit and release: occ unchanged, head rotates, rows_committed++.
- rows_committed saturates at cfg_rows. When it reaches cfg_rows, state becomes DONE, done=1 and in_ready=0. Release continues to work in DONE so the consumer can drain.
- Address arithmetic is modulo 2^ADR_W.

Test Plan:
1. words_per_row=2, rows=4, base=0x10, continuous valid -> we sequence buf1@0x10,0x11, buf2@0x10,0x11, buf3@0x10,0x11. in_ready drops after the 6th beat. idx=(1,2,3) and window_valid=1 from 2 cycles after the 6th beat.
2. Continue from 1 with a row_release pulse -> idx becomes (2,3,0) and window_valid=0. in_ready rises, the 4th row is written into buf1, then idx=(2,3,1). rows_committed=4, done=1, in_ready stays 0.
3. in_valid toggled 1/0 every cycle -> write strobes appear only one cycle after each accepted beat, with no gaps in the address count and the same final mapping as case 1.
4. row_release in the same cycle as the 3rd row's last beat commits (occ=2) -> occ stays 2, head=2, idx=(2,3,0). The next row goes to buf1.
5. Reset asserted after 1 beat of row 2 -> all outputs return to reset values next cycle. After start, row 1 is written to buf1 at word 0.
6. row_release with occ=0, and start pulsed during FILL -> both ignored: state, idx and counters unchanged.
